qfix_mul_iter: RTL

- Parametrised signed fixed-point multiplier, the successor to the fixed 64-bit Q-format multiplier.
- Keeps the same special-value encoding and adds four things:
  - configurable width and fraction bits;
  - an iterative digit-serial datapath (area over latency);
  - valid/ready handshakes on both sides;
  - selectable rounding and per-result status flags.
- Sits between the shading/intersection datapath and the shared FP-less arithmetic units. Each transaction is one product.

---
 rtl/qfix_pkg.sv | 39 +++
 rtl/qfix_decode.sv | 24 ++
 rtl/qfix_mul_iter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/qfix_pkg.sv
// Shared definitions for the Q-format multiplier family:
// special-value patterns, FSM states and status flag positions.
package qfix_pkg;

  localparam int MAXW = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_MUL,
    S_NORM,
    S_DONE
  } state_e;

  localparam int FLAG_NAN = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Patterns are built MAXW wide; callers truncate to their width.
  function automatic logic [MAXW-1:0] NAN_PAT(input int w);
    logic [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

  function automatic logic [MAXW-1:0] POS_INF_PAT(input int w);
    logic [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return NAN_PAT(w) - one;
  endfunction

  function automatic logic [MAXW-1:0] NEG_INF_PAT(input int w);
    logic [MAXW-1:0] one;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    return NAN_PAT(w) | one;
  endfunction

endpackage

// File: rtl/qfix_decode.sv
// Classifies a Q-format operand into sign / NaN / infinity / zero.
// Every other pattern is an ordinary finite value.
module qfix_decode
  import qfix_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x_i,
  output logic             sign_o,
  output logic             nan_o,
  output logic             inf_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] NAN_V  = WIDTH'(NAN_PAT(WIDTH));
  localparam logic [WIDTH-1:0] PINF_V = WIDTH'(POS_INF_PAT(WIDTH));
  localparam logic [WIDTH-1:0] NINF_V = WIDTH'(NEG_INF_PAT(WIDTH));

  assign sign_o = x_i[WIDTH-1];
  assign nan_o  = (x_i == NAN_V);
  assign inf_o  = (x_i == PINF_V) || (x_i == NINF_V);
  assign zero_o = (x_i == '0);

endmodule

// File: rtl/qfix_mul_iter.sv
// Iterative signed Q-format multiplier: digit-serial shift-add on
// magnitudes, then round/saturate, with valid/ready on both sides.
module qfix_mul_iter
  import qfix_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int FRAC          = 48,
  parameter int DIGIT_BITS    = 4,
  parameter int ROUND_NEAREST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int N  = WIDTH / DIGIT_BITS;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int RB = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [PW-1:0] FMASK = (ONE_P << FRAC) - ONE_P;
  localparam logic [PW-1:0] MAXM  = (ONE_P << (WIDTH - 1)) - ONE_P;

  localparam logic [WIDTH-1:0] NAN_V  = WIDTH'(NAN_PAT(WIDTH));
  localparam logic [WIDTH-1:0] PINF_V = WIDTH'(POS_INF_PAT(WIDTH));
  localparam logic [WIDTH-1:0] NINF_V = WIDTH'(NEG_INF_PAT(WIDTH));

  logic sa, na, ia, za;
  logic sb, nb, ib, zb;

  qfix_decode #(.WIDTH(WIDTH)) u_dec_a (
    .x_i   (a),
    .sign_o(sa),
    .nan_o (na),
    .inf_o (ia),
    .zero_o(za)
  );

  qfix_decode #(.WIDTH(WIDTH)) u_dec_b (
    .x_i   (b),
    .sign_o(sb),
    .nan_o (nb),
    .inf_o (ib),
    .zero_o(zb)
  );

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             nan_q, nan_d;
  logic             inf_q, inf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    pp, m, mr;
  logic             rbit, inx;
  logic             any_spec, spec_nan;

  always_comb begin
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    any_spec = na | nb | ia | ib | za | zb;
    spec_nan = na | nb | (ia & zb) | (ib & za);
    // One radix-2^DIGIT_BITS partial product per cycle.
    pp = '0;
    for (int j = 0; j < DIGIT_BITS; j++) begin
      if (mb_q[j]) pp = pp + (ma_q << j);
    end
    m    = acc_q >> FRAC;
    rbit = (ROUND_NEAREST != 0) && (FRAC > 0) && acc_q[RB];
    mr   = m + PW'(rbit);
    inx  = |(acc_q & FMASK);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    res_d   = res_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = sa ^ sb;
          nan_d   = spec_nan;
          inf_d   = (ia | ib) & ~spec_nan;
          acc_d   = '0;
          ma_d    = PW'(mag_a);
          mb_d    = mag_b;
          cnt_d   = '0;
          state_d = any_spec ? S_SPECIAL : S_MUL;
        end
      end
      S_SPECIAL: begin
        flags_d = '0;
        unique case (1'b1)
          nan_q: begin
            res_d             = NAN_V;
            flags_d[FLAG_NAN] = 1'b1;
          end
          inf_q:   res_d = sign_q ? NINF_V : PINF_V;
          default: res_d = '0;
        endcase
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d = acc_q + pp;
        ma_d  = ma_q << DIGIT_BITS;
        mb_d  = mb_q >> DIGIT_BITS;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        flags_d           = '0;
        flags_d[FLAG_INX] = inx;
        if (mr >= MAXM) begin
          res_d             = sign_q ? NINF_V : PINF_V;
          flags_d[FLAG_OVF] = 1'b1;
        end else if (mr == '0 && acc_q != '0) begin
          res_d             = '0;
          flags_d[FLAG_UNF] = 1'b1;
        end else begin
          // A zero magnitude here comes out as +0 either way.
          res_d = sign_q ? -mr[WIDTH-1:0] : mr[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign flags     = flags_q;

endmodule
